// File: rtl/lc3_prog_loader.sv
// LC-3 program loader: consumes an origin word plus program words,
// writes them into CPU memory and releases the CPU when the load completes.
module lc3_prog_loader #(
    parameter int MAX_WORDS = 32,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] pc_init,
    output logic [15:0]       word_count,
    output logic              cpu_run,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ORIGIN,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0]       MAX_C   = 17'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] PTR_TOP = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              wrap_q, wrap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        wrap_d   = wrap_q;
        in_ready = 1'b0;
        cpu_run  = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_ORIGIN;
                    cnt_d   = '0;
                end
            end
            S_ORIGIN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pc_d    = ADDR_W'(in_data);
                    ptr_d   = ADDR_W'(in_data);
                    wrap_d  = 1'b0;
                    state_d = in_last ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // wrap_q: the previous word landed at the top address
                    if (wrap_q) begin
                        state_d = S_ERR;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = in_data;
                        ptr_d   = ptr_q + 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                        wrap_d  = (ptr_q == PTR_TOP);
                        if (in_last) begin
                            state_d = S_DONE;
                        end else if ({1'b0, cnt_q} + 17'd1 == MAX_C) begin
                            state_d = S_ERR;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                cpu_run = 1'b1;
                if (load_start) begin
                    state_d = S_ORIGIN;
                    cnt_d   = '0;
                end
            end
            S_ERR: begin
                err = 1'b1;
                if (load_start) begin
                    state_d = S_ORIGIN;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign pc_init    = pc_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_lc3_prog_loader.sv
// Bench for lc3_prog_loader: directed scenarios plus randomized
// streams, checked against a word-list model of the load session.
module tb_lc3_prog_loader;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] pc_init;
    logic [15:0] word_count;
    logic        cpu_run;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [15:0] stim [0:7];
    logic [31:0] act_q [$];
    logic [31:0] exp_q [$];
    int          exp_acc;
    int          exp_cnt;
    logic        exp_done;
    logic        exp_err;

    lc3_prog_loader #(
        .MAX_WORDS(MAXW),
        .ADDR_W(16),
        .DATA_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_start(load_start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .pc_init(pc_init),
        .word_count(word_count),
        .cpu_run(cpu_run),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) act_q.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: word j (1-based) goes to origin+j-1 unless that passes
    // the top of memory; last wins over the MAX_WORDS limit.
    task automatic model(input logic [15:0] org, input int n,
                         input int lastpos);
        int a;
        exp_q.delete();
        exp_acc = 1;
        exp_cnt = 0;
        exp_done = 1'b0;
        exp_err = 1'b0;
        if (lastpos == 0) begin
            exp_done = 1'b1;
            return;
        end
        for (int j = 1; j <= n; j++) begin
            exp_acc++;
            a = int'(org) + j - 1;
            if (a > 65535) begin
                exp_err = 1'b1;
                return;
            end
            exp_q.push_back({a[15:0], stim[j]});
            exp_cnt = j;
            if (j == lastpos) begin
                exp_done = 1'b1;
                return;
            end
            if (exp_cnt == MAXW) begin
                exp_err = 1'b1;
                return;
            end
        end
    endtask

    task automatic send(input logic [15:0] d, input logic last,
                        input int budget, output bit ok);
        bit r;
        in_data = d;
        in_last = last;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            r = in_ready;
            @(negedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // stall < 0 picks a random 0..2 idle cycles before each word
    task automatic run_session(input string tag, input int n,
                               input int lastpos, input int stall);
        bit ok;
        int st;
        int nw;
        model(stim[0], n, lastpos);
        act_q.delete();
        pulse_start();
        for (int j = 0; j <= n; j++) begin
            st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            repeat (st) @(negedge clk);
            send(stim[j], (j == lastpos), (j < exp_acc) ? 4 : 3, ok);
            chk({tag, "_acc"}, 32'(ok), 32'(j < exp_acc));
            if (!ok || j >= exp_acc) break;
            if (j < exp_acc - 1) chk({tag, "_run_low"}, 32'(cpu_run), 0);
        end
        repeat (2) @(negedge clk);
        chk({tag, "_pc"}, 32'(pc_init), 32'(stim[0]));
        chk({tag, "_cnt"}, 32'(word_count), 32'(exp_cnt));
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_run"}, 32'(cpu_run), 32'(exp_done));
        chk({tag, "_rdy"}, 32'(in_ready), 0);
        chk({tag, "_nwr"}, 32'(act_q.size()), 32'(exp_q.size()));
        nw = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < nw; i++) chk({tag, "_wr"}, act_q[i], exp_q[i]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_pc"}, 32'(pc_init), 0);
        chk({tag, "_cnt"}, 32'(word_count), 0);
        chk({tag, "_run"}, 32'(cpu_run), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_rdy"}, 32'(in_ready), 0);
    endtask

    initial begin
        bit ok;
        int n;
        int lp;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        stim[0] = 16'h3000; stim[1] = 16'h16E8;
        stim[2] = 16'h1704; stim[3] = 16'hF025;
        run_session("nominal", 3, 3, 0);
        run_session("stalled", 3, 3, 2);

        stim[0] = 16'h4000;
        run_session("empty", 0, 0, 0);

        stim[0] = 16'h3000;
        for (int i = 1; i <= 5; i++) stim[i] = 16'h1000 + 16'(i);
        run_session("overflow", 5, -1, 0);

        stim[0] = 16'hFFFE; stim[1] = 16'hAAAA;
        stim[2] = 16'hBBBB; stim[3] = 16'hCCCC;
        run_session("wrap", 3, 3, 1);

        stim[0] = 16'h5000; stim[1] = 16'h1111;
        stim[2] = 16'h2222; stim[3] = 16'h3333;
        pulse_start();
        for (int j = 0; j <= 2; j++) send(stim[j], 1'b0, 4, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        stim[0] = 16'h6000; stim[1] = 16'h0A0A;
        stim[2] = 16'h0B0B;
        run_session("after_rst", 2, 2, 0);

        for (int t = 0; t < 14; t++) begin
            stim[0] = 16'($urandom);
            if ($urandom_range(0, 2) == 0)
                stim[0] = 16'hFFFF - 16'($urandom_range(0, 3));
            for (int i = 1; i < 8; i++) stim[i] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                n = 6;
                lp = -1;
            end else begin
                lp = $urandom_range(0, 6);
                n = lp;
            end
            run_session("rand", n, lp, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
